// File: rtl/npu_job_sequencer.sv
// NPU job sequencer: CSR-programmed weight-load / stream / drain controller with watchdog and IRQ.
// Optional busy-cycle counter at CSR 7 is built only when NPU_SEQ_PERF_EN is defined.
module npu_job_sequencer #(
  parameter int BEATS_PER_ROW = 4,
  parameter int CNT_W         = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_csr_write,
  input  logic             i_csr_read,
  input  logic [2:0]       i_csr_addr,
  input  logic [31:0]      i_csr_wdata,
  output logic [31:0]      o_csr_rdata,
  input  logic             i_sink_fire,
  input  logic             i_source_fire,
  output logic             o_sink_gate,
  output logic             o_pe_load_weight,
  output logic             o_pe_acc_clear,
  output logic [CNT_W-1:0] o_seq_total_rows,
  output logic             o_busy,
  output logic             o_irq
);

  // state  | meaning
  // IDLE   | waiting for START
  // LOAD_W | sink beats are weights
  // STREAM | sink beats are activations
  // DRAIN  | waiting for the last output beats
  // ERR    | one-cycle error exit
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD_W = 3'd1, S_STREAM = 3'd2, S_DRAIN = 3'd3, S_ERR = 3'd4
  } state_t;

  state_t r_state, w_next;
  logic r_irq_en, r_done, r_error, r_acc_clear;
  logic [CNT_W-1:0] r_w_beats, r_in_beats, r_out_rows, r_timeout;
  logic [CNT_W-1:0] r_sink_cnt, r_wd_left;
  logic [CNT_W+2:0] r_out_cnt;
  logic [31:0] r_rdata, w_rdata;

  logic w_ctrl_wr, w_status_wr, w_abort, w_idle_start, w_cfg_bad, w_job_start;
  logic w_active, w_any_fire, w_wd_expire, w_last_w, w_last_in, w_out_full;
  logic w_done_set, w_err_set, w_cfg_wr_ok;
  logic [CNT_W+2:0] w_out_target;

  assign w_ctrl_wr    = i_csr_write && (i_csr_addr == 3'd0);
  assign w_status_wr  = i_csr_write && (i_csr_addr == 3'd1);
  assign w_abort      = w_ctrl_wr && i_csr_wdata[1];
  assign w_idle_start = w_ctrl_wr && i_csr_wdata[0] && !i_csr_wdata[1] && (r_state == S_IDLE);
  assign w_cfg_bad    = (r_in_beats == '0) || (r_out_rows == '0);
  assign w_job_start  = w_idle_start && !w_cfg_bad;
  assign w_cfg_wr_ok  = i_csr_write && (r_state == S_IDLE);

  assign w_out_target = (CNT_W+3)'(r_out_rows) * (CNT_W+3)'(BEATS_PER_ROW);
  assign w_out_full   = (r_out_cnt == w_out_target);
  assign w_active     = (r_state == S_LOAD_W) || (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign w_any_fire   = i_sink_fire || i_source_fire;
  // Watchdog is a down-counter reloaded with TIMEOUT on start and on every fire.
  assign w_wd_expire  = (r_timeout != '0) && w_active && !w_any_fire && (r_wd_left == CNT_W'(1));
  assign w_last_w     = i_sink_fire && (r_sink_cnt == r_w_beats - CNT_W'(1));
  assign w_last_in    = i_sink_fire && (r_sink_cnt == r_in_beats - CNT_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_job_start) w_next = (r_w_beats != '0) ? S_LOAD_W : S_STREAM;
      S_LOAD_W: if (w_last_w)    w_next = S_STREAM;
      S_STREAM: if (w_last_in)   w_next = S_DRAIN;
      S_DRAIN:  if (w_out_full)  w_next = S_IDLE;
      S_ERR:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_wd_expire) w_next = S_ERR;
    if (w_abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_comb begin
    o_sink_gate      = (r_state == S_LOAD_W) || (r_state == S_STREAM);
    o_pe_load_weight = (r_state == S_LOAD_W);
    o_busy           = (r_state != S_IDLE);
    o_pe_acc_clear   = r_acc_clear;
    o_seq_total_rows = r_out_rows;
    o_irq            = r_irq_en && (r_done || r_error);
    o_csr_rdata      = r_rdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sink_cnt <= '0;
      r_out_cnt  <= '0;
      r_wd_left  <= '0;
    end else if (w_job_start) begin
      r_sink_cnt <= '0;
      r_out_cnt  <= '0;
      r_wd_left  <= r_timeout;
    end else begin
      if (i_sink_fire && (r_state == S_LOAD_W))
        r_sink_cnt <= w_last_w ? '0 : r_sink_cnt + CNT_W'(1);
      else if (i_sink_fire && (r_state == S_STREAM))
        r_sink_cnt <= r_sink_cnt + CNT_W'(1);
      if (w_active && i_source_fire && !w_out_full)
        r_out_cnt <= r_out_cnt + (CNT_W+3)'(1);
      if (w_any_fire)
        r_wd_left <= r_timeout;
      else if (w_active && (r_wd_left != '0))
        r_wd_left <= r_wd_left - CNT_W'(1);
    end
  end

  // A same-cycle set beats a W1C clear.
  assign w_done_set = (r_state == S_DRAIN) && w_out_full && !w_abort && !w_wd_expire;
  assign w_err_set  = (w_idle_start && w_cfg_bad) || (r_state == S_ERR) ||
                      (w_abort && (r_state != S_IDLE));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq_en    <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_acc_clear <= 1'b0;
      r_w_beats   <= '0;
      r_in_beats  <= '0;
      r_out_rows  <= '0;
      r_timeout   <= '0;
    end else begin
      r_acc_clear <= w_job_start;
      r_done      <= w_done_set || (r_done && !(w_status_wr && i_csr_wdata[1]));
      r_error     <= w_err_set  || (r_error && !(w_status_wr && i_csr_wdata[2]));
      if (w_ctrl_wr) r_irq_en <= i_csr_wdata[2];
      if (w_cfg_wr_ok && (i_csr_addr == 3'd2)) r_w_beats  <= CNT_W'(i_csr_wdata);
      if (w_cfg_wr_ok && (i_csr_addr == 3'd3)) r_in_beats <= CNT_W'(i_csr_wdata);
      if (w_cfg_wr_ok && (i_csr_addr == 3'd4)) r_out_rows <= CNT_W'(i_csr_wdata);
      if (w_cfg_wr_ok && (i_csr_addr == 3'd6)) r_timeout  <= CNT_W'(i_csr_wdata);
    end
  end

`ifdef NPU_SEQ_PERF_EN
  logic [31:0] r_perf;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                r_perf <= '0;
    else if (w_job_start)        r_perf <= '0;
    else if (r_state != S_IDLE)  r_perf <= r_perf + 32'd1;
  end
`endif

  always_comb begin
    w_rdata = '0;
    case (i_csr_addr)
      3'd0: w_rdata = {29'd0, r_irq_en, 2'b00};
      3'd1: w_rdata = {25'd0, r_state, 1'b0, r_error, r_done, o_busy};
      3'd2: w_rdata = 32'(r_w_beats);
      3'd3: w_rdata = 32'(r_in_beats);
      3'd4: w_rdata = 32'(r_out_rows);
      3'd5: w_rdata = 32'(r_out_cnt);
      3'd6: w_rdata = 32'(r_timeout);
`ifdef NPU_SEQ_PERF_EN
      3'd7: w_rdata = r_perf;
`endif
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        r_rdata <= '0;
    else if (i_csr_read) r_rdata <= w_rdata;
  end

endmodule
